// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
// Shared definitions for the hazard/stall controller: freeze-sequencer state
// encoding and the default register-index width.
package hazard_stall_ctrl_pkg;

    // Freeze sequencer states
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMulWait = 2'd1,
        StMemWait = 2'd2
    } state_e;

    localparam int unsigned DEF_REG_W = 4;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous reset, active-low
//   i_inc    - count this edge
//   i_clr    - synchronous clear, wins over i_inc
//   o_count  - current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard and stall controller sitting beside the ID stage. Detects RAW hazards
// between ID sources and EXE/MEM destinations (load-use only when forwarding
// is on), sequences whole-pipeline freezes for multi-cycle multiplies and
// memory-busy waits, and keeps stall/bubble statistics.
// Ports:
//   i_clk, i_rst_n            - clock, synchronous active-low reset
//   i_src1, i_src2, i_two_src - ID source registers, src2 valid flag
//   i_exe_dest, i_exe_wb_en, i_exe_mem_r_en - EXE destination, wb, load flag
//   i_mem_dest, i_mem_wb_en   - MEM destination and wb flag
//   i_forward_en              - forwarding unit active
//   i_mul_start, i_mem_busy   - multiply entering EXE, SRAM not ready
//   i_perf_clr                - clear statistics counters
//   o_hazard_detected, o_freeze_if, o_freeze_id, o_bubble_ex, o_freeze_back
//   o_stall_cycles, o_bubble_count - statistics
// Build option: define HAZ_PERF_CNT_EN to build the statistics counters;
// otherwise both counter outputs are tied to zero and i_perf_clr is ignored.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = DEF_REG_W,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_src1,
    input  logic [REG_W-1:0] i_src2,
    input  logic             i_two_src,
    input  logic [REG_W-1:0] i_exe_dest,
    input  logic             i_exe_wb_en,
    input  logic             i_exe_mem_r_en,
    input  logic [REG_W-1:0] i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic             i_forward_en,
    input  logic             i_mul_start,
    input  logic             i_mem_busy,
    input  logic             i_perf_clr,
    output logic             o_hazard_detected,
    output logic             o_freeze_if,
    output logic             o_freeze_id,
    output logic             o_bubble_ex,
    output logic             o_freeze_back,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_bubble_count
);

    localparam int unsigned MulCntW   = $clog2(MUL_LAT + 1);
    // The mul_start cycle is already frozen from RUN, so MUL_WAIT only has to
    // cover the remaining MUL_LAT-2 cycles; with MUL_LAT<=2 it is never used.
    localparam bit          MulFreeze = (MUL_LAT > 1);
    localparam bit          MulWaitEn = (MUL_LAT > 2);
    localparam int unsigned MulLoad   = MulWaitEn ? (MUL_LAT - 2) : 0;

    state_e               r_state;
    state_e               w_state_d;
    logic [MulCntW-1:0]   r_mul_cnt;
    logic [MulCntW-1:0]   w_mul_cnt_d;

    logic w_hit_e1, w_hit_e2, w_hit_m1, w_hit_m2;
    logic w_hazard;
    logic w_freeze_all;

    // RAW hazard detection
    assign w_hit_e1 = i_exe_wb_en & (i_src1 == i_exe_dest);
    assign w_hit_e2 = i_exe_wb_en & i_two_src & (i_src2 == i_exe_dest);
    assign w_hit_m1 = i_mem_wb_en & (i_src1 == i_mem_dest);
    assign w_hit_m2 = i_mem_wb_en & i_two_src & (i_src2 == i_mem_dest);

    // With forwarding, everything except a load in EXE can be bypassed.
    assign w_hazard = i_forward_en ? (i_exe_mem_r_en & (w_hit_e1 | w_hit_e2))
                                   : (w_hit_e1 | w_hit_e2 | w_hit_m1 | w_hit_m2);

    assign w_freeze_all = i_mem_busy
                        | (r_state == StMulWait)
                        | ((r_state == StRun) & i_mul_start & MulFreeze);

    assign o_hazard_detected = w_hazard;
    assign o_freeze_back     = w_freeze_all;
    assign o_freeze_if       = w_hazard | w_freeze_all;
    assign o_freeze_id       = w_hazard | w_freeze_all;
    // A bubble while the back end is held would overwrite the held ID/EX entry.
    assign o_bubble_ex       = w_hazard & ~w_freeze_all;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StRun;
            r_mul_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_mul_cnt <= w_mul_cnt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_mul_cnt_d = r_mul_cnt;
        unique case (r_state)
            StRun: begin
                // mem_busy wins; a held mul_start is seen again back in RUN.
                if (i_mem_busy) begin
                    w_state_d = StMemWait;
                end else if (i_mul_start && MulWaitEn) begin
                    w_state_d   = StMulWait;
                    w_mul_cnt_d = MulCntW'(MulLoad);
                end
            end
            StMulWait: begin
                // Leave when this cycle consumes the last remaining wait cycle.
                if (r_mul_cnt <= MulCntW'(1)) begin
                    w_mul_cnt_d = '0;
                    w_state_d   = i_mem_busy ? StMemWait : StRun;
                end else begin
                    w_mul_cnt_d = r_mul_cnt - MulCntW'(1);
                end
            end
            StMemWait: begin
                if (!i_mem_busy) begin
                    w_state_d = StRun;
                end
            end
            default: begin
                w_state_d   = StRun;
                w_mul_cnt_d = '0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_freeze_if),
        .i_clr   (i_perf_clr),
        .o_count (o_stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (o_bubble_ex),
        .i_clr   (i_perf_clr),
        .o_count (o_bubble_count)
    );
`else
    logic w_unused_perf_clr;
    assign w_unused_perf_clr = i_perf_clr;
    assign o_stall_cycles    = '0;
    assign o_bubble_count    = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Scoreboard bench for hazard_stall_ctrl: each driven cycle pushes the
// expected outputs from an independent behavioural model; a negedge monitor
// pops and compares them against the DUT.
module tb_hazard_stall_ctrl;

    localparam int unsigned REG_W   = 4;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
    logic             two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic             forward_en, mul_start, mem_busy, perf_clr;
    logic             hazard_detected, freeze_if, freeze_id, bubble_ex, freeze_back;
    logic [CNT_W-1:0] stall_cycles, bubble_count;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_W   (REG_W),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_src1            (src1),
        .i_src2            (src2),
        .i_two_src         (two_src),
        .i_exe_dest        (exe_dest),
        .i_exe_wb_en       (exe_wb_en),
        .i_exe_mem_r_en    (exe_mem_r_en),
        .i_mem_dest        (mem_dest),
        .i_mem_wb_en       (mem_wb_en),
        .i_forward_en      (forward_en),
        .i_mul_start       (mul_start),
        .i_mem_busy        (mem_busy),
        .i_perf_clr        (perf_clr),
        .o_hazard_detected (hazard_detected),
        .o_freeze_if       (freeze_if),
        .o_freeze_id       (freeze_id),
        .o_bubble_ex       (bubble_ex),
        .o_freeze_back     (freeze_back),
        .o_stall_cycles    (stall_cycles),
        .o_bubble_count    (bubble_count)
    );

    typedef struct packed {
        logic             haz;
        logic             fif;
        logic             fid;
        logic             bub;
        logic             fback;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] bubc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model state: 0 = run, 1 = multiply wait, 2 = memory wait
    int m_st    = 0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_bub   = 0;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("hazard_detected", 32'(hazard_detected), 32'(e.haz));
            check_val("freeze_if", 32'(freeze_if), 32'(e.fif));
            check_val("freeze_id", 32'(freeze_id), 32'(e.fid));
            check_val("bubble_ex", 32'(bubble_ex), 32'(e.bub));
            check_val("freeze_back", 32'(freeze_back), 32'(e.fback));
            check_val("stall_cycles", 32'(stall_cycles), 32'(e.stall));
            check_val("bubble_count", 32'(bubble_count), 32'(e.bubc));
        end
    end

    // Push this cycle's expectation, take one edge, advance the model.
    task automatic tick();
        exp_t e;
        bit he1, he2, hm1, hm2, haz, fa;
        he1 = exe_wb_en && (src1 == exe_dest);
        he2 = exe_wb_en && two_src && (src2 == exe_dest);
        hm1 = mem_wb_en && (src1 == mem_dest);
        hm2 = mem_wb_en && two_src && (src2 == mem_dest);
        haz = forward_en ? (exe_mem_r_en && (he1 || he2)) : (he1 || he2 || hm1 || hm2);
        fa  = mem_busy || (m_st == 1) || ((m_st == 0) && mul_start && (MUL_LAT > 1));
        e.haz   = haz;
        e.fif   = haz || fa;
        e.fid   = haz || fa;
        e.bub   = haz && !fa;
        e.fback = fa;
        e.stall = CNT_W'(m_stall);
        e.bubc  = CNT_W'(m_bub);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            m_st = 0; m_wait = 0; m_stall = 0; m_bub = 0;
        end else begin
            case (m_st)
                0: begin
                    if (mem_busy) m_st = 2;
                    else if (mul_start && (MUL_LAT > 2)) begin
                        m_st = 1; m_wait = MUL_LAT - 2;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_st = mem_busy ? 2 : 0;
                end
                default: if (!mem_busy) m_st = 0;
            endcase
            if (PERF) begin
                if (perf_clr) begin
                    m_stall = 0; m_bub = 0;
                end else begin
                    if (e.fif && m_stall < CNT_MAX) m_stall++;
                    if (e.bub && m_bub < CNT_MAX) m_bub++;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        src1 = 0; src2 = 0; two_src = 0; exe_dest = 0; exe_wb_en = 0;
        exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0; forward_en = 0;
        mul_start = 0; mem_busy = 0; perf_clr = 0;
    endtask

    task automatic set_exe_hazard();
        forward_en = 0; src1 = 3; exe_dest = 3; exe_wb_en = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        // Reset state
        tick();
        tick();
        rst_n = 1;
        tick();

        // EXE RAW hazard without forwarding, then bubble count after one edge
        set_exe_hazard();
        tick();
        idle_inputs();
        tick();

        // MEM match on src2 only counts when two_src is set
        src1 = 1; exe_dest = 3; exe_wb_en = 1; src2 = 5; mem_dest = 5; mem_wb_en = 1;
        two_src = 0;
        tick();
        two_src = 1;
        tick();

        // Forwarding: MEM match forwarded; load-use on src2 stalls
        forward_en = 1;
        tick();
        exe_dest = 5; exe_mem_r_en = 1;
        tick();
        idle_inputs();
        tick();

        // Multiply freeze with concurrent hazard
        set_exe_hazard();
        mul_start = 1;
        tick();
        mul_start = 0;
        tick();
        tick();
        idle_inputs();
        tick();

        // mem_busy and mul_start together, then mul_start re-sampled
        perf_clr = 1;
        tick();
        perf_clr = 0;
        mem_busy = 1; mul_start = 1;
        repeat (4) tick();
        mem_busy = 0;
        tick();
        mul_start = 0;
        repeat (3) tick();

        // Reset while in multiply wait
        mul_start = 1;
        tick();
        mul_start = 0; rst_n = 0;
        tick();
        rst_n = 1;
        repeat (2) tick();

        // Saturation: frozen back end with hazard, then hazard-only bubbles
        set_exe_hazard();
        mem_busy = 1;
        repeat (20) tick();
        mem_busy = 0;
        repeat (20) tick();
        // Clear wins over increment
        perf_clr = 1;
        tick();
        perf_clr = 0;
        repeat (2) tick();
        idle_inputs();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            src1 = REG_W'($urandom_range(0, 3));
            src2 = REG_W'($urandom_range(0, 3));
            exe_dest = REG_W'($urandom_range(0, 3));
            mem_dest = REG_W'($urandom_range(0, 3));
            two_src = 1'($urandom_range(0, 1));
            exe_wb_en = 1'($urandom_range(0, 1));
            exe_mem_r_en = 1'($urandom_range(0, 1));
            mem_wb_en = 1'($urandom_range(0, 1));
            forward_en = 1'($urandom_range(0, 1));
            mul_start = ($urandom_range(0, 5) == 0);
            mem_busy = ($urandom_range(0, 6) == 0);
            perf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        idle_inputs();

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check_val("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
